pc_update_unit: RTL
===================

// Module: pc_update_unit
// PURPOSE
//  Program-counter stage driven by the multicycle control unit: owns the PC register, resolves
//  branch conditions (BranchOp + ALU flags) into the PC write enable and selects the next PC.
//  Also holds EPC/Cause and runs a small exception-entry FSM that redirects fetch to a
//  vector on an exception request from the control unit or a misaligned branch/jump target.
// PARAMETERS
//  WIDTH         64        datapath/PC width in bits
//  RESET_PC      'h0       PC value after reset
//  EXC_VEC_BASE  'h100     exception vector base; target = EXC_VEC_BASE + (cause << 2)
// PORTS
//  clk          in   1      system clock, all state updates on rising edge
//  reset        in   1      synchronous, active-high reset
//  PCWrite      in   1      unconditional PC write (fetch PC+4, jal/jalr)
//  PCWriteCond  in   1      conditional PC write (branches)
//  PCSrc        in   1      0: next PC = ALUResult; 1: next PC = ALUOut
//  BranchOp     in   2      00 beq, 01 bne, 10 bge, 11 blt
//  Zero         in   1      ALU result == 0
//  Lt           in   1      ALU signed less-than (A < B)
//  ALUResult    in   WIDTH  live ALU output (PC+4 during fetch)
//  ALUOut       in   WIDTH  ALUOut register (branch/jump target)
//  ExcReq       in   1      exception request from control unit (1-cycle pulse)
//  ExcCauseIn   in   2      cause with ExcReq: 00 illegal opcode, 01 break/ecall
//  PC           out  WIDTH  current program counter
//  EPC          out  WIDTH  address of faulting instruction
//  Cause        out  2      latched cause; 10 = misaligned target (internal)
//  ExcBusy      out  1      high while exception FSM not IDLE
//  ExcDone      out  1      1-cycle pulse when vector load completes
//  ExcLost      out  1      sticky: ExcReq arrived while ExcBusy; cleared only by reset
// BEHAVIOUR
//  Reset (sync, dominates everything): PC=RESET_PC, EPC=0, Cause=0, FSM=IDLE, ExcBusy=0,
//   ExcDone=0, ExcLost=0. Reset mid-exception aborts the sequence; no partial EPC/Cause kept.
//  Branch cond: beq Zero; bne !Zero; bge !Lt; blt Lt.
//  take = PCWrite | (PCWriteCond & cond); next = PCSrc ? ALUOut : ALUResult.
//  IDLE: on take with next[1:0]==0 -> PC <= next at that edge (latency 1 edge, PC is a register).
//   take with next[1:0]!=0 -> PC unchanged, enter SAVE with cause 10.
//   ExcReq (with or without take) -> PC unchanged, enter SAVE with ExcCauseIn. ExcReq beats
//   misalignment and any PC write in the same cycle.
//  SAVE (1 cycle): EPC <= PC - 4 (fetch already advanced PC), Cause <= pending cause; -> VECTOR.
//  VECTOR (1 cycle): PC <= EXC_VEC_BASE + (Cause << 2); -> IDLE; ExcDone=1 in following cycle.
//  While SAVE/VECTOR: ExcBusy=1, PCWrite/PCWriteCond ignored; ExcReq sets ExcLost, no re-entry.
//  ExcBusy is combinational from state (state != IDLE); ExcDone, ExcLost registered.
//  Arithmetic modulo 2^WIDTH; PC - 4 at PC=0 wraps to all-ones-minus-3 without flag.
//  Cause width fixed at 2; vector offsets 0x0, 0x4, 0x8 for causes 00/01/10.
// STRUCTURE
//  Package pc_pkg: branch_op_t (BEQ/BNE/BGE/BLT), exc_cause_t (ILLEGAL/BREAK/MISALIGN),
//   exc_state_t (IDLE/SAVE/VECTOR).
//  Sub-module branch_cond: combinational BranchOp+Zero+Lt -> cond; instanced once.
//  Top: PC/EPC/Cause registers, pending-cause register, exception FSM.
// TESTING
//  1. reset, then PCWrite=1, PCSrc=0, ALUResult=4 -> PC=4 next edge; EPC=0, ExcBusy=0.
//  2. PCWriteCond=1, BranchOp=00, Zero=1, PCSrc=1, ALUOut=0x40 -> PC=0x40; Zero=0 -> PC hold.
//  3. BranchOp=11 blt: Lt=1 ALUOut=0x80 -> PC=0x80; BranchOp=10 bge Lt=1 -> PC hold.
//  4. PC=0x24, ExcReq=1 cause 00 -> SAVE: EPC=0x20, Cause=00; VECTOR: PC=0x100; ExcDone pulse.
//  5. PCWrite=1 PCSrc=1 ALUOut=0x42 -> PC hold, Cause=10, PC=0x108; ExcReq during busy -> ExcLost=1.
//  6. reset asserted in SAVE -> PC=RESET_PC, FSM IDLE, EPC=0, no ExcDone pulse afterwards.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the PC update stage: branch opcodes, exception causes, exception FSM states.
package pc_pkg;

    typedef enum logic [1:0] {
        BEQ = 2'b00,
        BNE = 2'b01,
        BGE = 2'b10,
        BLT = 2'b11
    } branch_op_t;

    typedef enum logic [1:0] {
        ILLEGAL  = 2'b00,
        BREAK    = 2'b01,
        MISALIGN = 2'b10
    } exc_cause_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SAVE   = 2'b01,
        VECTOR = 2'b10
    } exc_state_t;

endpackage

// File: rtl/branch_cond.sv
// Resolves a branch opcode and the ALU flags into a single taken/not-taken condition.
module branch_cond
    import pc_pkg::*;
(
    input  branch_op_t i_op,
    input  logic       i_zero,
    input  logic       i_lt,
    output logic       o_cond
);

    always_comb begin
        o_cond = 1'b0;
        case (i_op)
            BEQ: o_cond = i_zero;
            BNE: o_cond = ~i_zero;
            BGE: o_cond = ~i_lt;
            BLT: o_cond = i_lt;
            default: o_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_update_unit.sv
// PC register, branch resolution, EPC/Cause and the exception-entry sequence (IDLE -> SAVE -> VECTOR).
module pc_update_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 64,
    parameter logic [WIDTH-1:0] RESET_PC     = '0,
    parameter logic [WIDTH-1:0] EXC_VEC_BASE = WIDTH'('h100)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCWrite,
    input  logic             PCWriteCond,
    input  logic             PCSrc,
    input  logic [1:0]       BranchOp,
    input  logic             Zero,
    input  logic             Lt,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [WIDTH-1:0] ALUOut,
    input  logic             ExcReq,
    input  logic [1:0]       ExcCauseIn,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] EPC,
    output logic [1:0]       Cause,
    output logic             ExcBusy,
    output logic             ExcDone,
    output logic             ExcLost
);

    exc_state_t       r_state, w_state_nxt;
    exc_cause_t       r_pend, w_pend_nxt;
    exc_cause_t       r_cause, w_cause_nxt;
    logic [WIDTH-1:0] r_pc, w_pc_nxt;
    logic [WIDTH-1:0] r_epc, w_epc_nxt;
    logic             r_done, w_done_nxt;
    logic             r_lost, w_lost_nxt;

    logic             w_cond;
    logic             w_take;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_vector;

    branch_cond u_branch_cond (
        .i_op   (branch_op_t'(BranchOp)),
        .i_zero (Zero),
        .i_lt   (Lt),
        .o_cond (w_cond)
    );

    assign w_take   = PCWrite | (PCWriteCond & w_cond);
    assign w_target = PCSrc ? ALUOut : ALUResult;
    assign w_vector = EXC_VEC_BASE + {{(WIDTH-4){1'b0}}, r_cause, 2'b00};

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_cause_nxt = r_cause;
        w_pc_nxt    = r_pc;
        w_epc_nxt   = r_epc;
        w_done_nxt  = 1'b0;
        w_lost_nxt  = r_lost;
        case (r_state)
            IDLE: begin
                // A requested exception outranks both the PC write and a misaligned target.
                if (ExcReq) begin
                    w_pend_nxt  = exc_cause_t'(ExcCauseIn);
                    w_state_nxt = SAVE;
                end else if (w_take) begin
                    if (w_target[1:0] == 2'b00) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_pend_nxt  = MISALIGN;
                        w_state_nxt = SAVE;
                    end
                end
            end
            SAVE: begin
                // Fetch has already advanced PC past the faulting instruction.
                w_epc_nxt   = r_pc - WIDTH'(4);
                w_cause_nxt = r_pend;
                w_lost_nxt  = r_lost | ExcReq;
                w_state_nxt = VECTOR;
            end
            VECTOR: begin
                w_pc_nxt    = w_vector;
                w_done_nxt  = 1'b1;
                w_lost_nxt  = r_lost | ExcReq;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pend  <= ILLEGAL;
            r_cause <= ILLEGAL;
            r_pc    <= RESET_PC;
            r_epc   <= '0;
            r_done  <= 1'b0;
            r_lost  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_cause <= w_cause_nxt;
            r_pc    <= w_pc_nxt;
            r_epc   <= w_epc_nxt;
            r_done  <= w_done_nxt;
            r_lost  <= w_lost_nxt;
        end
    end

    assign PC      = r_pc;
    assign EPC     = r_epc;
    assign Cause   = r_cause;
    assign ExcBusy = (r_state != IDLE);
    assign ExcDone = r_done;
    assign ExcLost = r_lost;

endmodule
